// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters; all outputs registered.
// Grant 1 cycle after selection, start 1 cycle later; waits on master free, errors after BUSY_TIMEOUT start cycles.
module i2c_txn_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_LEN     = 7,
    parameter int DATA_LEN     = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]           req_rw,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data_1,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data_2,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           err,
    output logic                         busy,
    input  logic                         free,
    output logic                         start,
    output logic [ADDR_LEN-1:0]          add_reg,
    output logic                         R_W,
    output logic [DATA_LEN-1:0]          data_1,
    output logic [DATA_LEN-1:0]          data_2
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LATCH     = 3'd1;
    localparam logic [2:0] LAUNCH    = 3'd2;
    localparam logic [2:0] WAIT_FREE = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    logic [2:0]         state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      win;
    logic [PW-1:0]      sel;
    logic [PW-1:0]      win_nxt;
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] win_oh;

    // Scan downward so the requester closest above ptr is the last (winning) assignment.
    always_comb begin
        logic [PW:0] sum;
        sel = ptr;
        sum = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            if (req[sum[PW-1:0]]) begin
                sel = sum[PW-1:0];
            end
        end
    end

    assign win_oh  = ONE << win;
    assign win_nxt = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            busy    <= 1'b0;
            start   <= 1'b0;
            add_reg <= '0;
            R_W     <= 1'b0;
            data_1  <= '0;
            data_2  <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    if ((|req) && free) begin
                        win   <= sel;
                        state <= LATCH;
                        busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    add_reg <= req_addr[int'(win)*ADDR_LEN +: ADDR_LEN];
                    R_W     <= req_rw[win];
                    data_1  <= req_data_1[int'(win)*DATA_LEN +: DATA_LEN];
                    data_2  <= req_data_2[int'(win)*DATA_LEN +: DATA_LEN];
                    gnt     <= win_oh;
                    cnt     <= '0;
                    state   <= LAUNCH;
                end
                LAUNCH: begin
                    // Only a busy master seen while start is already visible counts as a launch.
                    if (start && !free) begin
                        start <= 1'b0;
                        state <= WAIT_FREE;
                    end else if (cnt == CW'(BUSY_TIMEOUT)) begin
                        start <= 1'b0;
                        gnt   <= '0;
                        err   <= win_oh;
                        ptr   <= win_nxt;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        start <= 1'b1;
                        cnt   <= cnt + 1'b1;
                    end
                end
                WAIT_FREE: begin
                    if (free) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= win_oh;
                    gnt   <= '0;
                    ptr   <= win_nxt;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    start <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: transaction-timeline reference model, reactive I2C master model,
// directed scenarios plus a randomized phase.
module tb_i2c_txn_arbiter;

    localparam int NUM = 4;
    localparam int AL  = 7;
    localparam int DL  = 8;
    localparam int TO  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NUM-1:0]  req;
    logic [NUM*AL-1:0] req_addr;
    logic [NUM-1:0]  req_rw;
    logic [NUM*DL-1:0] req_data_1;
    logic [NUM*DL-1:0] req_data_2;
    logic [NUM-1:0]  gnt, done, err;
    logic            busy, free, start, R_W;
    logic [AL-1:0]   add_reg;
    logic [DL-1:0]   data_1, data_2;
    logic            m_free;
    logic            ext_ok;

    assign free = m_free & ext_ok;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(.NUM_REQ(NUM), .ADDR_LEN(AL), .DATA_LEN(DL), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_data_1(req_data_1), .req_data_2(req_data_2), .gnt(gnt), .done(done),
        .err(err), .busy(busy), .free(free), .start(start), .add_reg(add_reg),
        .R_W(R_W), .data_1(data_1), .data_2(data_2)
    );

    function automatic logic [NUM-1:0] oh(input int i);
        return NUM'(1) << i;
    endfunction

    // Reference model: per transaction, outputs are a function of edges since selection.
    int t, m_n, m_w, m_f, m_b, rr;
    bit act, mvalid;
    int cur_f, cur_b, dir_f, dir_b;
    logic [NUM-1:0] exp_gnt, exp_done, exp_err;
    logic exp_busy, exp_start, exp_rw;
    logic [AL-1:0] exp_addr;
    logic [DL-1:0] exp_d1, exp_d2;

    task automatic model_step();
        int d, end_d, n_start, idx;
        bit found;
        t++;
        exp_done = '0;
        exp_err  = '0;
        if (rst === 1'b1) begin
            act = 0; rr = 0; mvalid = 1;
            exp_gnt = '0; exp_busy = 0; exp_start = 0;
            exp_addr = '0; exp_rw = 0; exp_d1 = '0; exp_d2 = '0;
            return;
        end
        if (act) begin
            d       = t - m_n;
            n_start = (m_f > TO) ? TO : m_f;
            end_d   = (m_f > TO) ? TO + 2 : m_f + m_b + 3;
            if (d == 1) begin
                exp_gnt  = oh(m_w);
                exp_addr = req_addr[m_w*AL +: AL];
                exp_rw   = ((req_rw >> m_w) & NUM'(1)) != 0;
                exp_d1   = req_data_1[m_w*DL +: DL];
                exp_d2   = req_data_2[m_w*DL +: DL];
            end
            exp_start = (d >= 2) && (d <= n_start + 1);
            if (d == end_d) begin
                act = 0;
                exp_gnt = '0; exp_busy = 0; exp_start = 0;
                rr = (m_w + 1) % NUM;
                if (m_f > TO) exp_err = oh(m_w);
                else exp_done = oh(m_w);
            end
        end else if (req != '0 && free === 1'b1) begin
            found = 0;
            for (int k = 0; k < NUM; k++) begin
                idx = (rr + k) % NUM;
                if (!found && ((req >> idx) & NUM'(1)) != 0) begin
                    m_w = idx;
                    found = 1;
                end
            end
            act = 1; m_n = t; exp_busy = 1;
            if (dir_f != 0) begin
                m_f = dir_f; m_b = dir_b;
            end else begin
                m_f = $urandom_range(1, 20); m_b = $urandom_range(1, 6);
            end
            cur_f = m_f; cur_b = m_b;
        end
    endtask

    initial begin
        t = 0; act = 0; mvalid = 0; rr = 0; m_n = 0; m_w = 0; m_f = 1; m_b = 1;
        cur_f = 1; cur_b = 1;
        exp_gnt = '0; exp_done = '0; exp_err = '0; exp_busy = 0; exp_start = 0;
        exp_addr = '0; exp_rw = 0; exp_d1 = '0; exp_d2 = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Master model: free falls cur_f cycles after start rises, stays low cur_b cycles.
    initial begin
        int c;
        m_free = 1'b1;
        forever begin
            @(negedge clk);
            if (start === 1'b1) begin
                c = 1;
                while (start === 1'b1 && c < cur_f) begin
                    @(negedge clk);
                    c++;
                end
                if (start === 1'b1) begin
                    m_free = 1'b0;
                    repeat (cur_b) @(negedge clk);
                    m_free = 1'b1;
                end
            end
        end
    end

    int checks = 0, errors = 0;
    int start_cyc = 0, done_cyc = 0, err_cyc = 0;
    logic [NUM-1:0] last_done = '0, last_err = '0, prev_gnt = '0;
    logic [NUM-1:0] glog[$];
    bit hold_all = 0, rnd_mode = 0;

    task automatic cmp(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: dut=%0h expected=%0h", nm, $time, act_v, exp_v);
        end
    endtask

    task automatic set_req(input int i, input logic [AL-1:0] a, input logic rw,
                           input logic [DL-1:0] d1, input logic [DL-1:0] d2);
        req_addr[i*AL +: AL]   = a;
        req_data_1[i*DL +: DL] = d1;
        req_data_2[i*DL +: DL] = d2;
        if (rw) req_rw = req_rw | oh(i);
        else req_rw = req_rw & ~oh(i);
        req = req | oh(i);
    endtask

    task automatic rnd_stim();
        if (exp_gnt != '0 && $urandom_range(0, 63) == 0) req = req & ~exp_gnt;
        if (ext_ok && !exp_busy && req == '0 && $urandom_range(0, 15) == 0) begin
            ext_ok = 1'b0;
        end else begin
            if (!ext_ok && $urandom_range(0, 5) == 0) ext_ok = 1'b1;
            for (int i = 0; i < NUM; i++) begin
                if (((req >> i) & NUM'(1)) == 0 && $urandom_range(0, 7) == 0) begin
                    set_req(i, AL'($urandom), 1'($urandom), DL'($urandom), DL'($urandom));
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mvalid) begin
            cmp("gnt", 32'(gnt), 32'(exp_gnt));
            cmp("done", 32'(done), 32'(exp_done));
            cmp("err", 32'(err), 32'(exp_err));
            cmp("busy", 32'(busy), 32'(exp_busy));
            cmp("start", 32'(start), 32'(exp_start));
            cmp("add_reg", 32'(add_reg), 32'(exp_addr));
            cmp("R_W", 32'(R_W), 32'(exp_rw));
            cmp("data_1", 32'(data_1), 32'(exp_d1));
            cmp("data_2", 32'(data_2), 32'(exp_d2));
        end
        if (start === 1'b1) start_cyc++;
        if (done != '0) begin done_cyc++; last_done = done; end
        if (err != '0) begin err_cyc++; last_err = err; end
        if (gnt != '0 && prev_gnt == '0) glog.push_back(gnt);
        prev_gnt = gnt;
        if (!hold_all) req = req & ~(exp_done | exp_err);
        if (rnd_mode) rnd_stim();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int sc0, dc0, ec0, gi;
        rst = 1'b1; req = '0; req_addr = '0; req_rw = '0; req_data_1 = '0; req_data_2 = '0;
        ext_ok = 1'b1; dir_f = 0; dir_b = 0;
        repeat (3) tick();
        rst = 1'b0;
        cmp("reset gnt", 32'(gnt), 32'h0);
        cmp("reset busy", 32'(busy), 32'h0);
        cmp("reset start", 32'(start), 32'h0);
        cmp("reset add_reg", 32'(add_reg), 32'h0);

        // single request, master busy 3 cycles after start, for 40 cycles
        sc0 = start_cyc; dc0 = done_cyc;
        dir_f = 3; dir_b = 40;
        set_req(0, 7'h52, 1'b0, 8'hA5, 8'h3C);
        repeat (60) tick();
        cmp("single add_reg", 32'(add_reg), 32'h52);
        cmp("single R_W", 32'(R_W), 32'h0);
        cmp("single data_1", 32'(data_1), 32'hA5);
        cmp("single data_2", 32'(data_2), 32'h3C);
        cmp("single start cycles", 32'(start_cyc - sc0), 32'd3);
        cmp("single done cycles", 32'(done_cyc - dc0), 32'd1);
        cmp("single done value", 32'(last_done), 32'b0001);

        // simultaneous 0101 from reset
        do_reset();
        dir_f = 2; dir_b = 3; gi = glog.size();
        set_req(0, 7'h11, 1'b1, 8'h01, 8'h02);
        set_req(2, 7'h33, 1'b0, 8'h03, 8'h04);
        repeat (40) tick();
        cmp("pair grant count", 32'(glog.size() - gi), 32'd2);
        cmp("pair grant 1st", 32'(glog[gi]), 32'b0001);
        cmp("pair grant 2nd", 32'(glog[gi+1]), 32'b0100);

        // all four continuously requesting
        do_reset();
        hold_all = 1; dir_f = 1; dir_b = 1; gi = glog.size();
        for (int i = 0; i < NUM; i++) set_req(i, AL'(7'h20 + i), 1'(i), DL'(i), DL'(i + 8));
        repeat (34) tick();
        cmp("rr grant 0", 32'(glog[gi]), 32'b0001);
        cmp("rr grant 1", 32'(glog[gi+1]), 32'b0010);
        cmp("rr grant 2", 32'(glog[gi+2]), 32'b0100);
        cmp("rr grant 3", 32'(glog[gi+3]), 32'b1000);
        cmp("rr grant wrap", 32'(glog[gi+4]), 32'b0001);
        hold_all = 0; req = '0;
        repeat (12) tick();

        // master never goes busy: launch timeout
        sc0 = start_cyc; dc0 = done_cyc; ec0 = err_cyc;
        dir_f = 100; dir_b = 1;
        set_req(1, 7'h45, 1'b1, 8'h55, 8'h66);
        repeat (30) tick();
        cmp("timeout start cycles", 32'(start_cyc - sc0), 32'd16);
        cmp("timeout err cycles", 32'(err_cyc - ec0), 32'd1);
        cmp("timeout err value", 32'(last_err), 32'b0010);
        cmp("timeout no done", 32'(done_cyc - dc0), 32'd0);

        // master busy when the request rises
        ext_ok = 1'b0;
        set_req(2, 7'h7F, 1'b0, 8'hFF, 8'h00);
        repeat (10) tick();
        cmp("blocked gnt", 32'(gnt), 32'h0);
        cmp("blocked busy", 32'(busy), 32'h0);
        gi = glog.size(); dc0 = done_cyc;
        dir_f = 2; dir_b = 2; ext_ok = 1'b1;
        repeat (20) tick();
        cmp("unblocked grant", 32'(glog[gi]), 32'b0100);
        cmp("unblocked done", 32'(done_cyc - dc0), 32'd1);

        // reset during WAIT_FREE
        dc0 = done_cyc; ec0 = err_cyc;
        dir_f = 2; dir_b = 30;
        set_req(2, 7'h0A, 1'b1, 8'h12, 8'h34);
        repeat (8) tick();
        cmp("pre-reset busy", 32'(busy), 32'h1);
        rst = 1'b1; req = '0;
        tick();
        cmp("midrst gnt", 32'(gnt), 32'h0);
        cmp("midrst start", 32'(start), 32'h0);
        cmp("midrst busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (40) tick();
        cmp("midrst no done", 32'(done_cyc - dc0), 32'd0);
        cmp("midrst no err", 32'(err_cyc - ec0), 32'd0);
        gi = glog.size(); dir_f = 1; dir_b = 1;
        set_req(1, 7'h01, 1'b0, 8'h0F, 8'hF0);
        set_req(3, 7'h03, 1'b1, 8'h1E, 8'hE1);
        repeat (20) tick();
        cmp("ptr cleared grant", 32'(glog[gi]), 32'b0010);
        cmp("ptr cleared next", 32'(glog[gi+1]), 32'b1000);

        // randomized traffic against the model
        dir_f = 0; rnd_mode = 1;
        repeat (3000) tick();
        rnd_mode = 0; req = '0; ext_ok = 1'b1;
        repeat (60) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin transaction arbiter that shares one I2C master controller between `NUM_REQ` independent requesters. Each requester presents a complete transaction (slave address, R/W, two data bytes); the arbiter picks one, holds its fields stable on the master's inputs, pulses the master's `start`, and tracks the master's `free` flag to detect launch and completion. It sits directly in front of the I2C master, with its outputs wired straight to the master's `start`, `add_reg`, `R_W`, `data_1`, `data_2` inputs and its `free` output.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_LEN`, 7: slave address width; matches the master.
- `DATA_LEN`, 8: data byte width; matches the master.
- `BUSY_TIMEOUT`, 16: maximum number of cycles `start` is held waiting for `free` to fall.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester transaction request; level, held until `done[i]` or `err[i]`.
- `req_addr`  in  NUM_REQ*ADDR_LEN  flattened addresses; requester i occupies slice [i*ADDR_LEN +: ADDR_LEN].
- `req_rw`  in  NUM_REQ  R/W bit per requester.
- `req_data_1`  in  NUM_REQ*DATA_LEN  flattened first data byte.
- `req_data_2`  in  NUM_REQ*DATA_LEN  flattened second data byte.
- `gnt`  out  NUM_REQ  one-hot grant; high from latch to completion.
- `done`  out  NUM_REQ  one-hot one-cycle completion pulse.
- `err`  out  NUM_REQ  one-hot one-cycle pulse on launch timeout.
- `busy`  out  1  high whenever state is not IDLE.
- `free`  in  1  master idle flag (1 = idle).
- `start`  out  1  master start request.
- `add_reg`  out  ADDR_LEN  latched address to the master.
- `R_W`  out  1  latched R/W to the master.
- `data_1`  out  DATA_LEN  latched byte 1 to the master.
- `data_2`  out  DATA_LEN  latched byte 2 to the master.

## Operation
- State machine: IDLE, LATCH, LAUNCH, WAIT_FREE, DONE.
- IDLE: if `|req && free`, select the winner and go to LATCH. Otherwise stay in IDLE. A request arriving while `free`=0 waits.
- Winner selection: the first set `req` bit scanning upward from `ptr` modulo NUM_REQ. `ptr` is a $clog2(NUM_REQ)-bit register.
- LATCH (1 cycle):
  - Register the winner's address, R/W and both data bytes into the master-facing outputs.
  - Set `gnt[winner]`.
  - Go to LAUNCH.
- LAUNCH:
  - Assert `start`.
  - Hold it until `free`=0 is sampled, then go to WAIT_FREE.
  - A cycle counter counts LAUNCH cycles. If it reaches BUSY_TIMEOUT with `free` still 1:
    - drop `start` and `gnt`;
    - pulse `err[winner]`;
    - set `ptr` = winner+1 (wrapping);
    - return to IDLE.
- WAIT_FREE: `start`=0. Stay until `free`=1, then go to DONE.
- DONE (1 cycle):
  - Pulse `done[winner]` and clear `gnt`.
  - Set `ptr` = winner+1, wrapping to 0 at NUM_REQ.
  - Return to IDLE.
- Master-facing data outputs hold their last latched value in all states and change only in LATCH.
- A requester dropping `req` mid-transaction does not abort; the transaction completes and `done` still pulses. Requester inputs are sampled only in IDLE (selection) and LATCH (fields).
- `req[winner]` still high in the IDLE cycle after DONE is treated as a new request. Round-robin ordering applies, so other pending requesters win first.
- `busy` = (state != IDLE).
- Reset values: state IDLE, `ptr`=0, counter 0; `gnt`, `done`, `err`, `busy`, `start` all 0; `add_reg`, `R_W`, `data_1`, `data_2` all 0.
- Reset mid-transaction: everything returns to reset values on the next edge. `start` drops immediately and no `done`/`err` pulse is issued. Recovering the master is the master's own reset's job.

## Timing
- All outputs are registered.
- The request is seen in IDLE at edge N. `gnt` and the data fields are valid after edge N+1 (LATCH). `start` is high after edge N+2.
- `start` is high for at least 1 and at most BUSY_TIMEOUT cycles.
- Completion is seen when `free` returns to 1 at edge M. `done` is high for the cycle after edge M+1, and `gnt` falls on the same edge.
- Back-to-back throughput: the next transaction's LATCH can occur 2 cycles after DONE (IDLE, then LATCH).
- The timeout counter saturates. It resets on entry to LAUNCH.

## Test plan
- Single request: `req`=4'b0001, addr 7'h52, rw 0, data 8'hA5/8'h3C; model the master with `free` falling 3 cycles after `start` and rising 40 cycles later -> `add_reg`=7'h52, `data_1`=8'hA5, `data_2`=8'h3C, `start` high for 3 cycles, `done`=4'b0001 for exactly 1 cycle.
- Simultaneous `req`=4'b0101 from reset -> requester 0 is served first, then requester 2; `gnt` sequence 0001, 0100; no overlap.
- All four requesting continuously -> grant order 0,1,2,3,0 with `ptr` wrapping from 3 to 0.
- `free` held at 1 and never falls, `req`=4'b0010 -> `start` high for exactly BUSY_TIMEOUT=16 cycles, then `err`=4'b0010 pulses once and the state returns to IDLE.
- `free`=0 when `req` rises -> no `gnt` until `free`=1, then the normal sequence.
- `rst` asserted during WAIT_FREE -> `gnt`, `start`, `busy` are 0 next cycle; no `done`/`err`; `ptr`=0.
